// File: rtl/ioctl_rom_router_pkg.sv
// Shared types for the ioctl ROM download router: packer states, FIFO entry layout
// and the single-byte entry builder used by both packing modes.
package ioctl_rom_router_pkg;

  localparam int RR_ADDR_W    = 25;
  localparam int RR_MAX_PORTS = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_FLUSH    = 2'd2,
    S_PUSH     = 2'd3
  } rr_state_t;

  // waddr is the un-rebased word address; each port subtracts its own base at issue time.
  typedef struct packed {
    logic [RR_ADDR_W-2:0]    waddr;
    logic [15:0]             data;
    logic [1:0]              ds;
    logic [RR_MAX_PORTS-1:0] mask;
  } rr_entry_t;

  function automatic rr_entry_t rr_single(input logic [RR_ADDR_W-1:0] addr,
                                          input logic [7:0] data,
                                          input logic [RR_MAX_PORTS-1:0] mask);
    rr_entry_t e;
    e.waddr = addr[RR_ADDR_W-1:1];
    e.data  = {data, data};
    e.ds    = {addr[0], ~addr[0]};
    e.mask  = mask;
    return e;
  endfunction

endpackage

// File: rtl/ioctl_rom_router_fifo.sv
// Synchronous FIFO of router entries; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module ioctl_rom_router_fifo
  import ioctl_rom_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      push,
  input  rr_entry_t din,
  input  logic      pop,
  output rr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  rr_entry_t    mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes data_io download bytes into up to four SDRAM write ports with toggle req/ack.
// Define ROUTER_WORD_PACK_EN to pack byte pairs into 16-bit words; otherwise bytewise.
module ioctl_rom_router
  import ioctl_rom_router_pkg::*;
#(
  parameter int                              NUM_PORTS  = 2,
  parameter logic [7:0]                      INDEX      = 8'd0,
  parameter logic [NUM_PORTS*RR_ADDR_W-1:0]  PORT_BASE  = {25'h0000000, 25'h000c000},
  parameter logic [NUM_PORTS*RR_ADDR_W-1:0]  PORT_SIZE  = {25'h1000000, 25'h1000000},
  parameter int                              FIFO_DEPTH = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [RR_ADDR_W-1:0]    ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic [NUM_PORTS-1:0]    port_req,
  input  logic [NUM_PORTS-1:0]    port_ack,
  output logic [NUM_PORTS*23-1:0] port_a,
  output logic [NUM_PORTS*16-1:0] port_d,
  output logic [NUM_PORTS*2-1:0]  port_ds,
  output logic [NUM_PORTS-1:0]    port_we,
  output logic                    busy,
  output logic                    overflow,
  output logic                    rom_loaded,
  output logic [1:0]              dbg_state
);

  function automatic logic [RR_MAX_PORTS-1:0] hit_mask(input logic [RR_ADDR_W-1:0] addr);
    logic [RR_ADDR_W-1:0] base;
    logic [RR_ADDR_W-1:0] size;
    hit_mask = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      base = PORT_BASE[k*RR_ADDR_W +: RR_ADDR_W];
      size = PORT_SIZE[k*RR_ADDR_W +: RR_ADDR_W];
      hit_mask[k] = (addr >= base) && ((addr - base) < size);
    end
  endfunction

  function automatic logic [22:0] rebase(input logic [RR_ADDR_W-2:0] waddr, input int k);
    logic [RR_ADDR_W-1:0] diff;
    diff = {waddr, 1'b0} - PORT_BASE[k*RR_ADDR_W +: RR_ADDR_W];
    return diff[23:1];
  endfunction

  rr_state_t               state, state_n;
  logic                    wr_d, dl_d, dl_active, dl_rise, dl_fall, dl_done;
  logic [RR_MAX_PORTS-1:0] in_mask, cur_mask;
  logic [RR_ADDR_W-1:0]    cur_addr;
  logic [7:0]              cur_data;
  logic                    accept, push, pending;
  rr_entry_t               push_entry, head;
  logic                    fifo_full, fifo_empty, issue, pop, issued;
  logic [NUM_PORTS-1:0]    head_mask, busy_ports;

  // Only downloads addressed to this index count; a foreign download is invisible.
  assign dl_active = ioctl_download && (ioctl_index == INDEX);
  assign dl_rise   = dl_active && !dl_d;
  assign dl_fall   = !dl_active && dl_d;
  assign in_mask   = hit_mask(ioctl_addr);
  assign accept    = ioctl_wr && !wr_d && dl_active && (in_mask != '0);
  assign dbg_state = state;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_d     <= 1'b0;
      dl_d     <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
      cur_mask <= '0;
    end else begin
      wr_d <= ioctl_wr;
      dl_d <= dl_active;
      if (accept && state == S_IDLE) begin
        cur_addr <= ioctl_addr;
        cur_data <= ioctl_dout;
        cur_mask <= in_mask;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

`ifdef ROUTER_WORD_PACK_EN
  logic                    held_v, flush_pend, hold_set, hold_clr, pair;
  logic [RR_ADDR_W-1:0]    held_addr;
  logic [7:0]              held_data;
  logic [RR_MAX_PORTS-1:0] held_mask;

  assign pair    = held_v && cur_addr[0] && (cur_addr == held_addr + 1'b1) && (cur_mask == held_mask);
  assign pending = held_v || flush_pend;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      held_v     <= 1'b0;
      held_addr  <= '0;
      held_data  <= '0;
      held_mask  <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (hold_set) begin
        held_v    <= 1'b1;
        held_addr <= cur_addr;
        held_data <= cur_data;
        held_mask <= cur_mask;
      end else if (hold_clr) begin
        held_v <= 1'b0;
      end
      // Flush request survives until the packer is back in S_IDLE to act on it.
      if (dl_fall)               flush_pend <= 1'b1;
      else if (state == S_IDLE)  flush_pend <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (accept) state_n = S_CLASSIFY;
      S_CLASSIFY: state_n = (pair || (!held_v && !cur_addr[0])) ? S_IDLE : S_FLUSH;
      S_FLUSH:    state_n = S_PUSH;
      S_PUSH:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    hold_set   = 1'b0;
    hold_clr   = 1'b0;
    case (state)
      S_IDLE: if (flush_pend && held_v) begin
        push       = 1'b1;
        push_entry = rr_single(held_addr, held_data, held_mask);
        hold_clr   = 1'b1;
      end
      S_CLASSIFY: if (pair) begin
        push             = 1'b1;
        push_entry.waddr = held_addr[RR_ADDR_W-1:1];
        push_entry.data  = {cur_data, held_data};
        push_entry.ds    = 2'b11;
        push_entry.mask  = held_mask;
        hold_clr         = 1'b1;
      end else if (!held_v && !cur_addr[0]) begin
        hold_set = 1'b1;
      end
      S_FLUSH: if (held_v) begin
        push       = 1'b1;
        push_entry = rr_single(held_addr, held_data, held_mask);
        hold_clr   = 1'b1;
      end
      S_PUSH: if (!cur_addr[0]) begin
        hold_set = 1'b1;
      end else begin
        push       = 1'b1;
        push_entry = rr_single(cur_addr, cur_data, cur_mask);
      end
      default: ;
    endcase
  end
`else
  assign pending = 1'b0;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_CLASSIFY;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (state == S_CLASSIFY) begin
      push       = 1'b1;
      push_entry = rr_single(cur_addr, cur_data, cur_mask);
    end
  end
`endif

  ioctl_rom_router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head stays in the FIFO while outstanding; it retires once every masked ack has returned.
  assign head_mask  = head.mask[NUM_PORTS-1:0];
  assign busy_ports = port_req ^ port_ack;
  assign issue      = !fifo_empty && !issued && ((head_mask & busy_ports) == '0);
  assign pop        = issued && ((head_mask & busy_ports) == '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port_req <= '0;
      port_we  <= '0;
      port_a   <= '0;
      port_d   <= '0;
      port_ds  <= '0;
      issued   <= 1'b0;
    end else if (issue) begin
      issued   <= 1'b1;
      port_req <= port_req ^ head_mask;
      port_we  <= head_mask;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (head_mask[k]) begin
          port_a[k*23 +: 23] <= rebase(head.waddr, k);
          port_d[k*16 +: 16] <= head.data;
          port_ds[k*2 +: 2]  <= head.ds;
        end
      end
    end else begin
      if (pop) issued <= 1'b0;
      port_we <= port_we & busy_ports;
    end
  end

  assign busy = pending || !fifo_empty || issued || (state != S_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_done    <= 1'b0;
      overflow   <= 1'b0;
      rom_loaded <= 1'b0;
    end else if (dl_rise) begin
      dl_done    <= 1'b0;
      overflow   <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      if (dl_fall) dl_done <= 1'b1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (dl_done && !busy && !overflow) rom_loaded <= 1'b1;
    end
  end

endmodule
